// File: rtl/ctrl_bubble_stage_pkg.sv
// Shared definitions for the control-word bubble stage: field offsets of the
// packed control word, the NOP pattern and the stage state encoding.
package ctrl_pkg;

  localparam int SHIFT_BIT = 11;
  localparam int ALU_MSB   = 10;
  localparam int ALU_LSB   = 7;
  localparam int SIZE_MSB  = 6;
  localparam int SIZE_LSB  = 5;
  localparam int EN_BIT    = 4;
  localparam int RW_BIT    = 3;
  localparam int LOAD_BIT  = 2;
  localparam int S_BIT     = 1;
  localparam int RF_BIT    = 0;

  localparam logic [11:0] CTRL_NOP = 12'h000;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

endpackage

// File: rtl/ctrl_bubble_stage_sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones, never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  // count register with saturation at MAX_VAL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= {W{1'b0}};
    end else if (en && (count != MAX_VAL)) begin
      count <= count + W'(1'b1);
    end
  end

endmodule

// File: rtl/ctrl_bubble_stage.sv
// Registered control-word stage between the Control Unit and ID/EX: passes the
// word, substitutes NOPs on request, inserts multi-cycle bubbles, obeys stall/flush.
module ctrl_bubble_stage
  import ctrl_pkg::*;
#(
  parameter int                CTRL_W    = 12,
  parameter logic [CTRL_W-1:0] NOP_VALUE = CTRL_W'(CTRL_NOP),
  parameter int                CNT_W     = 3,
  parameter int                STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  input  logic              sel_nop_i,
  input  logic              bubble_req_i,
  input  logic [CNT_W-1:0]  bubble_len_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic [STAT_W-1:0] bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [CNT_W-1:0]   remaining_r;
  logic [CNT_W-1:0]   remaining_nxt_s;
  logic [CTRL_W-1:0]  ctrl_r;
  logic [CTRL_W-1:0]  ctrl_nxt_s;
  logic               valid_r;
  logic               valid_nxt_s;
  logic               cnt_en_s;
  logic               req_s;

  // a zero-length request is no request at all
  assign req_s = bubble_req_i & (bubble_len_i != CNT_ZERO);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= RUN;
      remaining_r <= CNT_ZERO;
    end else begin
      state_r     <= state_nxt_s;
      remaining_r <= remaining_nxt_s;
    end
  end

  // next-state logic: flush > stall > bubble > request
  always_comb begin
    state_nxt_s     = state_r;
    remaining_nxt_s = remaining_r;
    if (flush_i) begin
      state_nxt_s     = RUN;
      remaining_nxt_s = CNT_ZERO;
    end else if (stall_i) begin
      state_nxt_s     = state_r;
      remaining_nxt_s = remaining_r;
    end else begin
      case (state_r)
        BUBBLE: begin
          if (remaining_r <= CNT_ONE) begin
            state_nxt_s     = RUN;
            remaining_nxt_s = CNT_ZERO;
          end else begin
            state_nxt_s     = BUBBLE;
            remaining_nxt_s = remaining_r - CNT_ONE;
          end
        end
        RUN: begin
          if (req_s && (bubble_len_i != CNT_ONE)) begin
            state_nxt_s     = BUBBLE;
            remaining_nxt_s = bubble_len_i - CNT_ONE;
          end else begin
            state_nxt_s     = RUN;
            remaining_nxt_s = CNT_ZERO;
          end
        end
        default: begin
          state_nxt_s     = RUN;
          remaining_nxt_s = CNT_ZERO;
        end
      endcase
    end
  end

  // next registered outputs and bubble-count enable
  always_comb begin
    ctrl_nxt_s  = ctrl_r;
    valid_nxt_s = valid_r;
    cnt_en_s    = 1'b0;
    if (flush_i) begin
      ctrl_nxt_s  = NOP_VALUE;
      valid_nxt_s = 1'b0;
    end else if (stall_i) begin
      ctrl_nxt_s  = ctrl_r;
      valid_nxt_s = valid_r;
    end else if ((state_r == BUBBLE) || req_s || sel_nop_i) begin
      ctrl_nxt_s  = NOP_VALUE;
      valid_nxt_s = 1'b0;
      cnt_en_s    = 1'b1;
    end else begin
      ctrl_nxt_s  = ctrl_i;
      valid_nxt_s = valid_i;
    end
  end

  // output pipeline register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r  <= NOP_VALUE;
      valid_r <= 1'b0;
    end else begin
      ctrl_r  <= ctrl_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  sat_counter #(
    .W(STAT_W)
  ) u_bubble_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cnt_en_s),
    .count   (bubble_cnt_o)
  );

  assign ctrl_o  = ctrl_r;
  assign valid_o = valid_r;
  // held low in reset so upstream never stalls on a stale request
  assign busy_o  = reset_n & ((state_r == BUBBLE) | ((state_r == RUN) & req_s));

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Scoreboard bench for ctrl_bubble_stage: directed steps push expected outputs,
// a monitor pops and compares one cycle later.
module tb_ctrl_bubble_stage;

  localparam int CTRL_W = 12;
  localparam int CNT_W  = 3;
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_i;
  logic              sel_nop_i;
  logic              bubble_req_i;
  logic [CNT_W-1:0]  bubble_len_i;
  logic              stall_i;
  logic              flush_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic              valid_o;
  logic              busy_o;
  logic [STAT_W-1:0] bubble_cnt_o;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
    logic [STAT_W-1:0] cnt;
    int                id;
  } exp_t;

  exp_t sb_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  ctrl_bubble_stage #(
    .CTRL_W    (CTRL_W),
    .NOP_VALUE (12'h000),
    .CNT_W     (CNT_W),
    .STAT_W    (STAT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ctrl_i       (ctrl_i),
    .valid_i      (valid_i),
    .sel_nop_i    (sel_nop_i),
    .bubble_req_i (bubble_req_i),
    .bubble_len_i (bubble_len_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .ctrl_o       (ctrl_o),
    .valid_o      (valid_o),
    .busy_o       (busy_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, id, got, want);
    end
  endtask

  // drive one cycle of inputs, check busy_o, queue the post-edge expectation
  task automatic step(input logic [CTRL_W-1:0] c, input logic v, input logic s, input logic r,
                      input logic [CNT_W-1:0] l, input logic st, input logic fl,
                      input logic eb, input logic [CTRL_W-1:0] ec, input logic ev,
                      input logic [STAT_W-1:0] ecnt);
    @(negedge clk);
    ctrl_i       = c;
    valid_i      = v;
    sel_nop_i    = s;
    bubble_req_i = r;
    bubble_len_i = l;
    stall_i      = st;
    flush_i      = fl;
    #1;
    step_id++;
    check("busy", step_id, {31'd0, busy_o}, {31'd0, eb});
    sb_q.push_back('{ec, ev, ecnt, step_id});
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("ctrl",  e.id, {20'd0, ctrl_o},       {20'd0, e.ctrl});
        check("valid", e.id, {31'd0, valid_o},      {31'd0, e.valid});
        check("cnt",   e.id, {28'd0, bubble_cnt_o}, {28'd0, e.cnt});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_n      = 1'b0;
    ctrl_i       = 12'h000;
    valid_i      = 1'b0;
    sel_nop_i    = 1'b0;
    bubble_req_i = 1'b1;
    bubble_len_i = 3'd3;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    #12;
    check("rst_ctrl",  0, {20'd0, ctrl_o},       32'h0);
    check("rst_valid", 0, {31'd0, valid_o},      32'h0);
    check("rst_cnt",   0, {28'd0, bubble_cnt_o}, 32'h0);
    check("rst_busy",  0, {31'd0, busy_o},       32'h0);
    @(negedge clk);
    reset_n      = 1'b1;
    bubble_req_i = 1'b0;

    //   ctrl     v     sel   req   len   stall flush busy  exp_ctrl exp_v cnt
    step(12'hABC, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'hABC, 1'b1, 4'd0);
    step(12'h5A5, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 4'd1);
    step(12'h5A5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'h5A5, 1'b1, 4'd1);
    // three-cycle bubble
    step(12'h123, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 4'd2);
    step(12'h123, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 4'd3);
    step(12'h123, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 4'd4);
    step(12'h123, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1, 4'd4);
    // three-cycle bubble with a stall on the second NOP cycle
    step(12'h777, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 4'd5);
    step(12'h777, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 4'd5);
    step(12'h777, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 4'd6);
    step(12'h777, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 4'd7);
    step(12'h777, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'h777, 1'b1, 4'd7);
    // flush together with stall mid-bubble
    step(12'h321, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 4'd8);
    step(12'h321, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 4'd8);
    step(12'h321, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'h321, 1'b1, 4'd8);
    // zero-length request, single-cycle request, stall and flush in RUN
    step(12'h456, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b1, 4'd8);
    step(12'h456, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 4'd9);
    step(12'h456, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b1, 4'd9);
    step(12'h999, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 12'h456, 1'b1, 4'd9);
    step(12'h999, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 4'd9);
    // single NOPs drive the 4-bit counter into saturation at 15
    for (int i = 0; i < 10; i++) begin
      step(12'h0F0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0,
           (i < 5) ? 4'(10 + i) : 4'd15);
    end
    // start a bubble, then reset in the middle of it
    step(12'hABC, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 4'd15);
    step(12'hABC, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 4'd15);
    @(posedge clk);
    #3;
    reset_n      = 1'b0;
    bubble_req_i = 1'b1;
    bubble_len_i = 3'd3;
    #1;
    check("arst_ctrl",  step_id, {20'd0, ctrl_o},       32'h0);
    check("arst_valid", step_id, {31'd0, valid_o},      32'h0);
    check("arst_cnt",   step_id, {28'd0, bubble_cnt_o}, 32'h0);
    check("arst_busy",  step_id, {31'd0, busy_o},       32'h0);
    @(negedge clk);
    reset_n      = 1'b1;
    bubble_req_i = 1'b0;
    bubble_len_i = 3'd0;
    step(12'hABC, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'hABC, 1'b1, 4'd0);

    repeat (3) @(negedge clk);
    check("drain", step_id, sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
